sap_core_param: RTL and testbench
=================================

// Module: sap_core_param
// PURPOSE
//  Parametrised next-generation SAP-style multicycle CPU core: accumulator A, operand reg B,
//  PC, IR, MAR, unified RAM, carry/zero flags and a hard-wired control FSM (no microcode ROM).
//  Adds conditional jumps, valid/ready IN/OUT ports with backpressure, and a RAM program-load
//  port usable while stopped. Sits at chip top level between the I/O pins and the debug mux.
// PARAMETERS
//  DATA_W    8   data/instruction word width; must satisfy DATA_W >= 4 + ADDR_W
//  ADDR_W    4   RAM address width; depth = 2**ADDR_W words
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  run        in   1       start execution at PC=0 (sampled in IDLE/HALT only)
//  prog_we    in   1       RAM write strobe (honoured in IDLE/HALT only)
//  prog_addr  in   ADDR_W  RAM write address
//  prog_data  in   DATA_W  RAM write data
//  in_valid   in   1       input word available
//  in_data    in   DATA_W  input word
//  in_ready   out  1       core consuming input (IN instruction waiting)
//  out_valid  out  1       out_data holds an unconsumed OUT result
//  out_data   out  DATA_W  value of A at the OUT instruction, stable while out_valid
//  out_ready  in   1       sink accepts out_data
//  busy       out  1       high in any state other than IDLE/HALT
//  halted     out  1       high in HALT
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; PC,A,B,IR,MAR,carry,zero,out_data=0; out_valid,in_ready,busy,
//   halted=0, all immediately. RAM contents are NOT cleared.
//  Instruction word: opcode=IR[DATA_W-1 -:4], operand=IR[ADDR_W-1:0] (imm = zero-extended).
//  States: IDLE, F0, F1, E1, E2, E3, IN_WAIT, OUT_WAIT, HALT.
//   IDLE/HALT --run--> F0 with PC<=0 (A, flags kept). prog_we writes RAM same cycle (write
//    precedes first fetch if both asserted). prog_we ignored in all other states.
//   F0: MAR<=PC.  F1: IR<=RAM[MAR], PC<=PC+1 (wraps 2**ADDR_W-1 -> 0).  Then E1.
//  Opcodes (cycles incl. 2 fetch):
//   0 NOP 3 | 1 LDA a: E1 MAR<=a, E2 A<=RAM 4 | 2 ADD a / 3 SUB a: E1 MAR<=a, E2 B<=RAM,
//   E3 A<=A+B or A+~B+1, carry<=bit DATA_W, zero<=(result==0) 5 | 4 STA a: E1 MAR<=a,
//   E2 RAM[MAR]<=A 4 | 5 LDI i: A<=i 3 | 6 JMP a: PC<=a 3 | 7 JC a / 8 JZ a: PC<=a if flag
//   else no change 3 | 9 IN -> IN_WAIT | E OUT -> OUT_WAIT | F HLT -> HALT | A-D: as NOP.
//  Flags change only in E3 of ADD/SUB. SUB carry=1 means no borrow. Arithmetic mod 2**DATA_W.
//  IN_WAIT: in_ready=1; on in_valid: A<=in_data, go F0. Flags unchanged. Min 1 cycle.
//  OUT_WAIT: out_data<=A on entry, out_valid=1 next cycle; held stable until out_valid&out_ready,
//   then out_valid<=0, go F0. out_data retains last value afterwards.
//  HALT: halted=1, busy=0; holds all registers until run or reset.
//  Reset mid-instruction (incl. IN/OUT wait): abort, handshake outputs drop at once; a RAM
//   write in progress on the same edge is not guaranteed.
//  Exactly one state transition per clock; no combinational path from in_*/out_ready to RAM.
// TESTING
//  1. RAM: 0:LDI 5, 1:ADD E, 2:OUT, 3:HLT, E:3; run pulse, out_ready=1 -> out_data=8 one
//     handshake, halted=1 after 3+5+3(+OUT)+3 cycles; carry=0, zero=0.
//  2. A=FF via LDA, ADD of 01 -> A=00, carry=1, zero=1; following JC 8 taken (PC=8), JZ taken.
//  3. LDI 5; SUB of 5 -> zero=1, carry=1; SUB of 6 from 5 -> A=FF, carry=0, zero=0; JC not taken.
//  4. OUT with out_ready=0 for 10 cycles -> out_valid=1, out_data constant, PC unchanged, busy=1;
//     out_ready=1 -> single transfer, fetch resumes next cycle.
//  5. IN with in_valid=0 for 5 cycles then in_data=2A -> A=2A, flags unchanged; assert reset
//     during a second IN_WAIT -> in_ready=0 same cycle, state IDLE, RAM contents unchanged.
//  6. Program with NOP at addr F (ADDR_W=4), jump there -> next fetch from addr 0; prog_we while
//     busy -> RAM unchanged; rerun from HALT restarts at 0 with A retained.

Source files
------------

// File: rtl/sap_core_param.sv
// sap_core_param -- multicycle SAP-style accumulator CPU with a hard-wired control FSM.
//
// Datapath: accumulator A, operand register B, PC, IR, MAR, unified RAM of
// 2**ADDR_W words, and carry/zero flags. Adds conditional jumps, valid/ready
// IN and OUT ports with backpressure, and a RAM program-load port that is
// honoured only while the core is stopped (IDLE or HALT).
// DATA_W must be >= 4 + ADDR_W so that the opcode and operand fields fit.
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_reset      asynchronous reset, active low
//   i_run        start execution at PC=0 (sampled in IDLE/HALT only)
//   i_prog_we    RAM write strobe (IDLE/HALT only)
//   i_prog_addr  RAM write address
//   i_prog_data  RAM write data
//   i_in_valid   input word available
//   i_in_data    input word
//   o_in_ready   IN instruction is waiting for a word
//   o_out_valid  o_out_data holds an unconsumed OUT result
//   o_out_data   A captured at the OUT instruction, stable while o_out_valid
//   i_out_ready  sink accepts o_out_data
//   o_busy       core is in any state other than IDLE/HALT
//   o_halted     core is in HALT
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_halted
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_E1, S_E2, S_E3, S_IN_WAIT, S_OUT_WAIT, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_pc, r_mar;
  logic [DATA_W-1:0]   r_a, r_b, r_ir, r_out_data;
  logic                r_carry, r_zero, r_out_valid;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_opd;
  logic                w_stopped, w_is_sub;
  logic [DATA_W-1:0]   w_b_op;
  logic [DATA_W:0]     w_sum;

  assign w_op      = r_ir[DATA_W-1 -: 4];
  assign w_opd     = r_ir[ADDR_W-1:0];
  assign w_stopped = (r_state == S_IDLE) || (r_state == S_HALT);

  // SUB is A + ~B + 1; the carry out is then "no borrow".
  assign w_is_sub = (w_op == OP_SUB);
  assign w_b_op   = w_is_sub ? ~r_b : r_b;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_is_sub};

  // Handshake/status outputs decode the state register directly, so they
  // drop the moment reset forces the state to IDLE.
  assign o_in_ready  = (r_state == S_IN_WAIT);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = !w_stopped;
  assign o_halted    = (r_state == S_HALT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (i_run) w_next = S_F0;
      S_F0:           w_next = S_F1;
      S_F1:           w_next = S_E1;
      S_E1: begin
        case (w_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w_next = S_E2;
          OP_IN:                          w_next = S_IN_WAIT;
          OP_OUT:                         w_next = S_OUT_WAIT;
          OP_HLT:                         w_next = S_HALT;
          default:                        w_next = S_F0;
        endcase
      end
      S_E2:       w_next = (w_op == OP_ADD || w_op == OP_SUB) ? S_E3 : S_F0;
      S_E3:       w_next = S_F0;
      S_IN_WAIT:  if (i_in_valid) w_next = S_F0;
      S_OUT_WAIT: if (r_out_valid && i_out_ready) w_next = S_F0;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ir        <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: if (i_run) r_pc <= '0;
        S_F0: r_mar <= r_pc;
        S_F1: begin
          r_ir <= r_mem[r_mar];
          r_pc <= r_pc + ADDR_W'(1);
        end
        S_E1: begin
          case (w_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= w_opd;
            OP_LDI: r_a  <= {{(DATA_W-ADDR_W){1'b0}}, w_opd};
            OP_JMP: r_pc <= w_opd;
            OP_JC:  if (r_carry) r_pc <= w_opd;
            OP_JZ:  if (r_zero)  r_pc <= w_opd;
            OP_OUT: begin
              r_out_data  <= r_a;
              r_out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        S_E2: begin
          if (w_op == OP_LDA) r_a <= r_mem[r_mar];
          if (w_op == OP_ADD || w_op == OP_SUB) r_b <= r_mem[r_mar];
        end
        S_E3: begin
          r_a     <= w_sum[DATA_W-1:0];
          r_carry <= w_sum[DATA_W];
          r_zero  <= (w_sum[DATA_W-1:0] == '0);
        end
        S_IN_WAIT:  if (i_in_valid) r_a <= i_in_data;
        S_OUT_WAIT: if (i_out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // RAM has no reset. The load port and STA never overlap: one needs a
  // stopped core, the other the E2 state.
  always_ff @(posedge i_clk) begin
    if (w_stopped && i_prog_we)
      r_mem[i_prog_addr] <= i_prog_data;
    else if (r_state == S_E2 && w_op == OP_STA)
      r_mem[r_mar] <= r_a;
  end

endmodule

// File: tb/tb_sap_core_param.sv
module tb_sap_core_param;
  localparam int DW = 8, AW = 4, DEPTH = 16, MOD = 256;

  logic          i_clk, i_reset, i_run, i_prog_we, i_in_valid, i_out_ready;
  logic [AW-1:0] i_prog_addr;
  logic [DW-1:0] i_prog_data, i_in_data, o_out_data;
  logic          o_in_ready, o_out_valid, o_busy, o_halted;

  int checks = 0, errors = 0;
  int prog[DEPTH];
  int m_mem[DEPTH];
  int m_a, m_c, m_z;
  int in_vals[16];
  int in_idx;
  int exp_q[$];
  int got_q[$];

  sap_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_prog_we(i_prog_we),
    .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_halted(o_halted));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_nout"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_out"}, (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < DEPTH; k++) prog[k] = v;
  endtask

  task automatic load_prog();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge i_clk);
      i_prog_we = 1'b1; i_prog_addr = AW'(k); i_prog_data = DW'(prog[k]);
      m_mem[k] = prog[k];
    end
    @(negedge i_clk);
    i_prog_we = 1'b0;
  endtask

  // Wait for HALT, collecting OUT transfers and feeding IN words from in_vals.
  task automatic wait_halt(input int maxc, output int cyc);
    bit hs_in, to;
    cyc = 0; to = 0;
    forever begin
      @(negedge i_clk);
      if (o_halted) break;
      if (cyc >= maxc) begin to = 1; break; end
      cyc++;
      if (o_out_valid && i_out_ready) got_q.push_back(int'(o_out_data));
      hs_in = o_in_ready && i_in_valid;
      @(posedge i_clk); #1;
      if (hs_in) begin in_idx++; i_in_data = DW'(in_vals[in_idx % 16]); end
    end
    i_prog_we = 1'b0;
    check("halt_timeout", {31'b0, to}, 0);
  endtask

  task automatic run_prog(input int maxc, input bit we_busy, output int cyc);
    got_q.delete();
    in_idx = 0; i_in_data = DW'(in_vals[0]);
    @(negedge i_clk); i_run = 1'b1;
    @(posedge i_clk); #1; i_run = 1'b0;
    if (we_busy) begin i_prog_we = 1'b1; i_prog_addr = 4'hD; i_prog_data = 8'h55; end
    wait_halt(maxc, cyc);
  endtask

  task automatic wait_for(input int which, input int maxw);
    // which: 0 = out_valid, 1 = in_ready
    int w = 0;
    @(negedge i_clk);
    while (((which == 0) ? !o_out_valid : !o_in_ready) && w < maxw) begin
      @(negedge i_clk); w++;
    end
  endtask

  // Instruction-level reference: executes whole instructions, charging each
  // its documented cycle cost (IN/OUT assume the partner is always ready).
  task automatic model_run(output int cyc);
    int pc, ir, op, opd, s, steps, ii;
    bit done;
    pc = 0; cyc = 0; steps = 0; ii = 0; done = 0;
    exp_q.delete();
    while (!done && steps < 100) begin
      steps++;
      ir = m_mem[pc]; pc = (pc + 1) % DEPTH;
      op = ir / 16; opd = ir % DEPTH;
      case (op)
        1:  begin m_a = m_mem[opd]; cyc += 4; end
        2:  begin s = m_a + m_mem[opd]; m_c = (s >= MOD); m_a = s % MOD;
                  m_z = (m_a == 0); cyc += 5; end
        3:  begin m_c = (m_a >= m_mem[opd]); m_a = (m_a - m_mem[opd] + MOD) % MOD;
                  m_z = (m_a == 0); cyc += 5; end
        4:  begin m_mem[opd] = m_a; cyc += 4; end
        5:  begin m_a = opd; cyc += 3; end
        6:  begin pc = opd; cyc += 3; end
        7:  begin if (m_c != 0) pc = opd; cyc += 3; end
        8:  begin if (m_z != 0) pc = opd; cyc += 3; end
        9:  begin m_a = in_vals[ii % 16]; ii++; cyc += 4; end
        14: begin exp_q.push_back(m_a); cyc += 4; end
        15: begin cyc += 3; done = 1; end
        default: cyc += 3;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk); i_reset = 1'b0;
    @(negedge i_clk); i_reset = 1'b1;
    m_a = 0; m_c = 0; m_z = 0;
  endtask

  initial begin
    int cyc, ecyc, bad, k;
    i_reset = 1'b0; i_run = 0; i_prog_we = 0; i_prog_addr = '0; i_prog_data = '0;
    i_in_valid = 0; i_in_data = '0; i_out_ready = 0;
    for (int j = 0; j < 16; j++) in_vals[j] = 0;
    m_a = 0; m_c = 0; m_z = 0;
    #12;
    check("rst_in_ready", o_in_ready, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_data", o_out_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_halted", o_halted, 0);
    check("rst_pc", dut.r_pc, 0);
    check("rst_a", dut.r_a, 0);
    check("rst_flags", {dut.r_carry, dut.r_zero}, 0);
    @(negedge i_clk); i_reset = 1'b1;

    // T1: LDI 5; ADD E; OUT; HLT with RAM[E]=3
    fill(0); prog[0] = 'h55; prog[1] = 'h2E; prog[2] = 'hE0; prog[3] = 'hF0; prog[14] = 3;
    load_prog(); i_out_ready = 1;
    run_prog(100, 0, cyc);
    check("t1_cycles", cyc, 15);
    exp_q = '{8}; check_outs("t1");
    check("t1_halted", o_halted, 1);
    check("t1_busy", o_busy, 0);
    check("t1_carry", dut.r_carry, 0);
    check("t1_zero", dut.r_zero, 0);

    // T2: FF + 01 wraps to 00 with carry and zero; JC and JZ both taken
    fill('hF0); prog[0] = 'h1E; prog[1] = 'h2F; prog[2] = 'h78; prog[8] = 'h8B;
    prog[11] = 'hE0; prog[14] = 'hFF; prog[15] = 'h01;
    load_prog();
    run_prog(100, 0, cyc);
    check("t2_cycles", cyc, 22);
    exp_q = '{0}; check_outs("t2");
    check("t2_a", dut.r_a, 0);
    check("t2_carry", dut.r_carry, 1);
    check("t2_zero", dut.r_zero, 1);
    check("t2_pc", dut.r_pc, 13);

    // T3: 5-5 gives zero with no borrow; 5-6 gives FF with borrow, JC not taken
    fill('hF0); prog[0] = 'h55; prog[1] = 'h3E; prog[2] = 'h84; prog[4] = 'hE0;
    prog[5] = 'h55; prog[6] = 'h3F; prog[7] = 'h79; prog[8] = 'hE0;
    prog[14] = 5; prog[15] = 6;
    load_prog();
    run_prog(100, 0, cyc);
    check("t3_cycles", cyc, 33);
    exp_q = '{0, 'hFF}; check_outs("t3");
    check("t3_a", dut.r_a, 'hFF);
    check("t3_carry", dut.r_carry, 0);
    check("t3_zero", dut.r_zero, 0);

    // T4: OUT held off by the sink for 10 cycles
    fill('hF0); prog[0] = 'h57; prog[1] = 'hE0; prog[2] = 'h59; prog[3] = 'hE0;
    load_prog(); i_out_ready = 0; got_q.delete();
    @(negedge i_clk); i_run = 1'b1;
    @(posedge i_clk); #1; i_run = 1'b0;
    wait_for(0, 20);
    check("t4_valid_seen", o_out_valid, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge i_clk);
      check("t4_hold_valid", o_out_valid, 1);
      check("t4_hold_data", o_out_data, 'h07);
      check("t4_hold_busy", o_busy, 1);
      check("t4_hold_pc", dut.r_pc, 2);
    end
    i_out_ready = 1;
    @(negedge i_clk);
    check("t4_valid_drop", o_out_valid, 0);
    check("t4_data_kept", o_out_data, 'h07);
    @(negedge i_clk);
    check("t4_refetch_mar", dut.r_mar, 2);
    wait_halt(50, cyc);
    exp_q = '{9}; check_outs("t4");

    // T5: IN stalls without a word, then takes 2A; reset aborts a second IN
    fill('hF0); prog[0] = 'h53; prog[1] = 'h3E; prog[2] = 'h90; prog[3] = 'hE0;
    prog[4] = 'h90; prog[14] = 3;
    load_prog(); i_in_valid = 0; i_out_ready = 1;
    @(negedge i_clk); i_run = 1'b1;
    @(posedge i_clk); #1; i_run = 1'b0;
    wait_for(1, 20);
    for (int n = 0; n < 5; n++) begin
      check("t5_stall_ready", o_in_ready, 1);
      check("t5_stall_busy", o_busy, 1);
      @(negedge i_clk);
    end
    i_in_data = 8'h2A; i_in_valid = 1;
    @(negedge i_clk);
    check("t5_ready_drop", o_in_ready, 0);
    i_in_valid = 0;
    check("t5_a", dut.r_a, 'h2A);
    check("t5_flags_kept", {dut.r_carry, dut.r_zero}, 2'b11);
    wait_for(0, 20);
    check("t5_out_valid", o_out_valid, 1);
    check("t5_out_data", o_out_data, 'h2A);
    wait_for(1, 20);
    check("t5_second_in", o_in_ready, 1);
    i_reset = 1'b0; #1;
    check("t5_rst_in_ready", o_in_ready, 0);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_halted", o_halted, 0);
    check("t5_rst_out_valid", o_out_valid, 0);
    bad = 0;
    for (int j = 0; j < DEPTH; j++) if (int'(dut.r_mem[j]) != prog[j]) bad++;
    check("t5_ram_kept", bad, 0);
    @(negedge i_clk); i_reset = 1'b1;
    m_a = 0; m_c = 0; m_z = 0;

    // T6: NOP at the top address wraps the PC; load port ignored while busy
    fill('hF0); prog[0] = 'h84; prog[1] = 'h3D; prog[2] = 'hE0; prog[3] = 'h6F;
    prog[4] = 'hE0; prog[5] = 'h59; prog[6] = 'hE0; prog[13] = 0; prog[15] = 0;
    load_prog();
    run_prog(100, 0, cyc);
    check("t6_cycles", cyc, 35);
    exp_q = '{0, 0, 9}; check_outs("t6");
    run_prog(100, 1, cyc);
    check("t6_rerun_cycles", cyc, 17);
    exp_q = '{9, 9}; check_outs("t6_rerun");
    check("t6_busy_write", dut.r_mem[13], 0);

    // Randomized straight-line programs with forward branches only
    do_reset();
    i_in_valid = 1; i_out_ready = 1;
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 10; a++) begin
        k = $urandom_range(0, 11);
        case (k)
          0:  prog[a] = 'h00;
          1:  prog[a] = 'h10 + $urandom_range(11, 15);
          2:  prog[a] = 'h20 + $urandom_range(11, 15);
          3:  prog[a] = 'h30 + $urandom_range(11, 15);
          4:  prog[a] = 'h40 + $urandom_range(11, 15);
          5:  prog[a] = 'h50 + $urandom_range(0, 15);
          6:  prog[a] = 'h60 + $urandom_range(a + 1, 10);
          7:  prog[a] = 'h70 + $urandom_range(a + 1, 10);
          8:  prog[a] = 'h80 + $urandom_range(a + 1, 10);
          9:  prog[a] = 'h90;
          10: prog[a] = 'hE0;
          default: prog[a] = 'hA0 + 16 * $urandom_range(0, 3) + $urandom_range(0, 15);
        endcase
      end
      prog[10] = 'hF0;
      for (int a = 11; a < 16; a++) prog[a] = (p % 2 == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255);
      for (int j = 0; j < 16; j++) in_vals[j] = $urandom_range(0, 255);
      load_prog();
      model_run(ecyc);
      run_prog(200, 0, cyc);
      check("rnd_cycles", cyc, ecyc);
      check_outs("rnd");
      check("rnd_a", dut.r_a, m_a);
      check("rnd_carry", dut.r_carry, m_c);
      check("rnd_zero", dut.r_zero, m_z);
      bad = 0;
      for (int j = 11; j < DEPTH; j++) if (int'(dut.r_mem[j]) != m_mem[j]) bad++;
      check("rnd_ram", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
